// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared constants and fetch state encoding for the instruction fetch controller.
package inst_fetch_ctrl_pkg;

  localparam logic [31:0] IF_RESET_PC = 32'hbfc00000;
  localparam logic [31:0] INST_NOP    = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_HOLD   = 3'd3,
    S_CANCEL = 3'd4
  } fetchState_e;

  function automatic logic isMisaligned(input logic [1:0] lowBits);
    return lowBits != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bundle: PC register handshake, SRAM-like instruction port and IF/ID outputs.
interface inst_fetch_ctrl_if #(parameter int WIDTH = 32);

  logic [WIDTH-1:0] pc;
  logic             pc_en;
  logic             flush;
  logic             id_stall;
  logic             inst_req;
  logic [WIDTH-1:0] inst_addr;
  logic             inst_addr_ok;
  logic             inst_data_ok;
  logic [WIDTH-1:0] inst_rdata;
  logic             if_valid;
  logic [WIDTH-1:0] if_pc;
  logic [WIDTH-1:0] if_inst;
  logic             if_adel;

  modport master (
    input  pc, flush, id_stall, inst_addr_ok, inst_data_ok, inst_rdata,
    output pc_en, inst_req, inst_addr, if_valid, if_pc, if_inst, if_adel
  );

  modport slave (
    output pc, flush, id_stall, inst_addr_ok, inst_data_ok, inst_rdata,
    input  pc_en, inst_req, inst_addr, if_valid, if_pc, if_inst, if_adel
  );

endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: one memory transaction per instruction, delivers {pc, inst}
// to decode and pulses pc_en to advance the PC register.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(IF_RESET_PC)
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_ctrl_if.master bus
);

  fetchState_e      r_state;
  logic [WIDTH-1:0] r_addrQ;
  logic             r_cancelQ;
  logic             r_ifValid;
  logic [WIDTH-1:0] r_ifPc;
  logic [WIDTH-1:0] r_ifInst;
  logic             r_ifAdel;
  logic             w_misaligned;

  assign w_misaligned = isMisaligned(bus.pc[1:0]);

  // A flush while the request is still unaccepted is remembered in r_cancelQ so the
  // request can finish its handshake and its data be discarded in CANCEL.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addrQ   <= RESET_PC;
      r_cancelQ <= 1'b0;
      r_ifValid <= 1'b0;
      r_ifPc    <= RESET_PC;
      r_ifInst  <= WIDTH'(INST_NOP);
      r_ifAdel  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!bus.flush) begin
            if (w_misaligned) begin
              r_state   <= S_HOLD;
              r_ifValid <= 1'b1;
              r_ifAdel  <= 1'b1;
              r_ifPc    <= bus.pc;
              r_ifInst  <= WIDTH'(INST_NOP);
            end else begin
              r_addrQ <= bus.pc;
              r_state <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (bus.inst_addr_ok) begin
            if (bus.flush || r_cancelQ) begin
              r_state   <= S_CANCEL;
              r_cancelQ <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
          end else if (bus.flush) begin
            r_cancelQ <= 1'b1;
          end
        end
        S_DATA: begin
          if (bus.inst_data_ok) begin
            if (bus.flush) begin
              r_state <= S_IDLE;
            end else begin
              r_state   <= S_HOLD;
              r_ifInst  <= bus.inst_rdata;
              r_ifPc    <= r_addrQ;
              r_ifValid <= 1'b1;
              r_ifAdel  <= 1'b0;
            end
          end else if (bus.flush) begin
            r_state <= S_CANCEL;
          end
        end
        S_CANCEL: begin
          if (bus.inst_data_ok) begin
            r_state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (bus.flush || !bus.id_stall) begin
            r_state   <= S_IDLE;
            r_ifValid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.inst_req  = (r_state == S_ADDR);
  assign bus.inst_addr = r_addrQ;
  assign bus.pc_en     = (r_state == S_HOLD) && !bus.id_stall && !bus.flush;
  assign bus.if_valid  = r_ifValid;
  assign bus.if_pc     = r_ifPc;
  assign bus.if_inst   = r_ifInst;
  assign bus.if_adel   = r_ifAdel;

endmodule
